// File: rtl/adc_pattern_gen_pkg.sv
// Shared constants, types and the golden word unpacker for the synthetic ADC pattern source.
package adc_pattern_pkg;

  localparam int unsigned NSAMP           = 10;
  localparam int unsigned SWIDTH          = 12;
  localparam int unsigned CSWIDTH         = 2;
  localparam int unsigned CNTW            = 16;
  localparam int unsigned BITS_PER_SAMPLE = SWIDTH + CSWIDTH;
  localparam int unsigned WORDW           = NSAMP * BITS_PER_SAMPLE;
  localparam int unsigned WIDX            = $clog2(WORDW);
  localparam int unsigned SIDX            = $clog2(SWIDTH);

  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_RAMP  = 2'd1;
  localparam logic [1:0] MODE_PULSE = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [NSAMP-1:0][SWIDTH-1:0] samples_t;

  typedef struct packed {
    logic [1:0]         mode;
    logic [SWIDTH-1:0]  level_a;
    logic [SWIDTH-1:0]  level_b;
    logic [SWIDTH-1:0]  step;
    logic [CNTW-1:0]    period;
    logic [CNTW-1:0]    width;
    logic [CNTW-1:0]    burst;
    logic [CSWIDTH-1:0] clkstr;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    mode:    MODE_CONST,
    level_a: '0,
    level_b: '0,
    step:    '0,
    period:  CNTW'(1),
    width:   '0,
    burst:   '0,
    clkstr:  '0
  };

  // Inverse of lvds_word_pack: recover sample s from an interleaved word.
  function automatic logic [SWIDTH-1:0] unpack_sample(input logic [WORDW-1:0] word,
                                                      input int unsigned s);
    logic [SWIDTH-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < SWIDTH; b++) begin
      r[SIDX'(b)] = word[WIDX'(NSAMP * b + s)];
    end
    return r;
  endfunction

  function automatic logic [CSWIDTH-1:0] unpack_clkstr(input logic [WORDW-1:0] word,
                                                       input int unsigned s);
    logic [CSWIDTH-1:0] r;
    r = '0;
    for (int unsigned c = 0; c < CSWIDTH; c++) begin
      r[c] = word[WIDX'(NSAMP * (SWIDTH + c) + s)];
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_pattern_gen_if.sv
// Config, run-control and word output bundle between a controller and adc_pattern_gen.
interface adc_pattern_gen_if;
  import adc_pattern_pkg::*;

  logic [1:0]         cfg_mode;
  logic [SWIDTH-1:0]  cfg_level_a;
  logic [SWIDTH-1:0]  cfg_level_b;
  logic [SWIDTH-1:0]  cfg_step;
  logic [CNTW-1:0]    cfg_period;
  logic [CNTW-1:0]    cfg_width;
  logic [CNTW-1:0]    cfg_burst;
  logic [CSWIDTH-1:0] cfg_clkstr;
  logic               cfg_load;
  logic               cfg_ack;
  logic               start;
  logic               stop;
  logic               busy;
  logic [WORDW-1:0]   pat_bits;
  logic               pat_valid;
  logic               done;
  logic [CNTW-1:0]    word_count;

  modport master (
    output cfg_mode, cfg_level_a, cfg_level_b, cfg_step, cfg_period, cfg_width,
           cfg_burst, cfg_clkstr, cfg_load, start, stop,
    input  cfg_ack, busy, pat_bits, pat_valid, done, word_count
  );

  modport slave (
    input  cfg_mode, cfg_level_a, cfg_level_b, cfg_step, cfg_period, cfg_width,
           cfg_burst, cfg_clkstr, cfg_load, start, stop,
    output cfg_ack, busy, pat_bits, pat_valid, done, word_count
  );

endinterface

// File: rtl/adc_pattern_gen_lvds_word_pack.sv
// Combinational interleaver: sample s, bit b lands at word[NSAMP*b + s]; strobe bits above the value.
module lvds_word_pack
  import adc_pattern_pkg::*;
(
  input  samples_t           samples,
  input  logic [CSWIDTH-1:0] clkstr,
  output logic [WORDW-1:0]   word
);

  for (genvar s = 0; s < NSAMP; s++) begin : g_samp
    for (genvar b = 0; b < SWIDTH; b++) begin : g_val
      assign word[NSAMP*b + s] = samples[s][b];
    end
    for (genvar c = 0; c < CSWIDTH; c++) begin : g_str
      assign word[NSAMP*(SWIDTH + c) + s] = clkstr[c];
    end
  end

endmodule

// File: rtl/adc_pattern_gen.sv
// Synthetic ADC word source: constant, ramp and pulse patterns in the deserializer's interleaved format.
module adc_pattern_gen
  import adc_pattern_pkg::*;
(
  input logic              clklvds,
  input logic              rstn,
  adc_pattern_gen_if.slave bus
);

  state_t             state, state_next;
  cfg_t               cfg, cfg_in_c;
  logic               load_c, launch_c, emit_c, finish_c, pulse_hi_c;
  logic [SWIDTH-1:0]  base, launch_base_c;
  logic [CNTW-1:0]    phase, phase_inc_c, phase_next_c, period_eff_c, word_count;
  logic               cfg_ack, pat_valid, done;
  logic [WORDW-1:0]   pat_bits, word_c;
  samples_t           samples_c;

  always_comb begin
    cfg_in_c         = CFG_RESET;
    cfg_in_c.mode    = bus.cfg_mode;
    cfg_in_c.level_a = bus.cfg_level_a;
    cfg_in_c.level_b = bus.cfg_level_b;
    cfg_in_c.step    = bus.cfg_step;
    cfg_in_c.period  = bus.cfg_period;
    cfg_in_c.width   = bus.cfg_width;
    cfg_in_c.burst   = bus.cfg_burst;
    cfg_in_c.clkstr  = bus.cfg_clkstr;
  end

  // A load coinciding with start must seed the run with the incoming level.
  assign load_c        = (state == IDLE) && bus.cfg_load;
  assign launch_base_c = load_c ? cfg_in_c.level_a : cfg.level_a;

  assign period_eff_c = (cfg.period == '0) ? CNTW'(1) : cfg.period;
  assign phase_inc_c  = phase + CNTW'(1);
  assign phase_next_c = (phase_inc_c >= period_eff_c) ? '0 : phase_inc_c;
  assign pulse_hi_c   = (phase < cfg.width);

  for (genvar s = 0; s < NSAMP; s++) begin : g_samp
    assign samples_c[s] = (cfg.mode == MODE_RAMP)               ? base + SWIDTH'(s) * cfg.step :
                          (cfg.mode == MODE_PULSE && pulse_hi_c) ? cfg.level_b : cfg.level_a;
  end

  lvds_word_pack u_pack (
    .samples (samples_c),
    .clkstr  (cfg.clkstr),
    .word    (word_c)
  );

  always_comb begin
    state_next = state;
    launch_c   = 1'b0;
    emit_c     = 1'b0;
    finish_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_next = RUN;
          launch_c   = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_next = IDLE;
        end else if (cfg.burst != '0 && word_count == cfg.burst) begin
          state_next = IDLE;
          finish_c   = 1'b1;
        end else begin
          emit_c = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clklvds or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clklvds or negedge rstn) begin
    if (!rstn) begin
      cfg        <= CFG_RESET;
      cfg_ack    <= 1'b0;
      done       <= 1'b0;
      pat_valid  <= 1'b0;
      pat_bits   <= '0;
      word_count <= '0;
      base       <= '0;
      phase      <= '0;
    end else begin
      cfg_ack   <= load_c;
      done      <= finish_c;
      pat_valid <= emit_c;
      if (load_c) cfg <= cfg_in_c;
      if (launch_c) begin
        word_count <= '0;
        base       <= launch_base_c;
        phase      <= '0;
      end else if (emit_c) begin
        pat_bits <= word_c;
        if (word_count != '1) word_count <= word_count + CNTW'(1);
        base  <= base + SWIDTH'(NSAMP) * cfg.step;
        phase <= phase_next_c;
      end
    end
  end

  assign bus.cfg_ack    = cfg_ack;
  assign bus.busy       = (state == RUN);
  assign bus.pat_bits   = pat_bits;
  assign bus.pat_valid  = pat_valid;
  assign bus.done       = done;
  assign bus.word_count = word_count;

endmodule

// File: tb/tb_adc_pattern_gen.sv
// Randomized self-checking bench for adc_pattern_gen against an arithmetic pattern model.
module tb_adc_pattern_gen;

  logic clklvds = 1'b0;
  logic rstn    = 1'b0;
  always #5 clklvds = ~clklvds;

  adc_pattern_gen_if bus ();

  adc_pattern_gen dut (
    .clklvds (clklvds),
    .rstn    (rstn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int m_mode, m_la, m_lb, m_step, m_period, m_width, m_burst, m_clk;
  logic [139:0] got_q[$];
  int bad_k, bad_s;

  function automatic int exp_sample(int k, int s);
    int pe;
    case (m_mode)
      1: return (m_la + (10 * k + s) * m_step) % 4096;
      2: begin
        pe = (m_period == 0) ? 1 : m_period;
        return ((k % pe) < m_width) ? m_lb : m_la;
      end
      default: return m_la;
    endcase
  endfunction

  function automatic int unpk(logic [139:0] w, int s);
    logic [139:0] t;
    int r = 0;
    for (int b = 0; b < 12; b++) begin
      t = w >> (10 * b + s);
      if (t[0]) r += (1 << b);
    end
    return r;
  endfunction

  function automatic int unpk_clk(logic [139:0] w, int s);
    logic [139:0] t0, t1;
    t0 = w >> (120 + s);
    t1 = w >> (130 + s);
    return (t1[0] ? 2 : 0) + (t0[0] ? 1 : 0);
  endfunction

  // Number of captured words that disagree with the model anywhere.
  function automatic int word_errs();
    int e = 0;
    bit bad;
    bad_k = -1;
    bad_s = -1;
    for (int k = 0; k < got_q.size(); k++) begin
      bad = 1'b0;
      for (int s = 0; s < 10; s++) begin
        if (!bad && (unpk(got_q[k], s) != exp_sample(k, s) || unpk_clk(got_q[k], s) != m_clk)) begin
          bad = 1'b1;
          if (bad_k < 0) begin bad_k = k; bad_s = s; end
        end
      end
      if (bad) e++;
    end
    return e;
  endfunction

  task automatic drive_cfg();
    bus.cfg_mode    = 2'(m_mode);
    bus.cfg_level_a = 12'(m_la);
    bus.cfg_level_b = 12'(m_lb);
    bus.cfg_step    = 12'(m_step);
    bus.cfg_period  = 16'(m_period);
    bus.cfg_width   = 16'(m_width);
    bus.cfg_burst   = 16'(m_burst);
    bus.cfg_clkstr  = 2'(m_clk);
  endtask

  task automatic load_cfg(output bit ack);
    drive_cfg();
    bus.cfg_load = 1'b1;
    @(negedge clklvds);
    ack = bus.cfg_ack;
    bus.cfg_load = 1'b0;
  endtask

  task automatic do_run(input int maxc, output int nvalid, output int ndone, output bit tmo);
    int cyc = 0;
    got_q.delete();
    nvalid = 0;
    ndone  = 0;
    bus.start = 1'b1;
    @(negedge clklvds);
    bus.start = 1'b0;
    while (bus.busy && cyc < maxc) begin
      @(negedge clklvds);
      cyc++;
      if (bus.pat_valid) begin nvalid++; got_q.push_back(bus.pat_bits); end
      if (bus.done) ndone++;
    end
    tmo = bus.busy;
    @(negedge clklvds);
    if (bus.done) ndone++;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.busy, bus.pat_valid, bus.done, bus.cfg_ack} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=0000", {bus.busy, bus.pat_valid, bus.done, bus.cfg_ack});
    end
    n_checks++;
    if (bus.word_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_word_count got=%0d exp=0", bus.word_count);
    end
    n_checks++;
    if (bus.pat_bits !== 140'd0) begin
      n_fail++; $display("FAIL reset_pat_bits got=%h exp=0", bus.pat_bits);
    end
  endtask

  task automatic test_const();
    bit ack, tmo;
    int nv, nd, e;
    logic [139:0] w;
    m_mode = 0; m_la = 'h5A5; m_lb = 0; m_step = 0; m_period = 1; m_width = 0; m_burst = 1; m_clk = 1;
    load_cfg(ack);
    n_checks++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL const_ack got=%b exp=1", ack); end
    do_run(10, nv, nd, tmo);
    n_checks++;
    if (nv != 1 || nd != 1 || tmo) begin
      n_fail++; $display("FAIL const_burst valid=%0d done=%0d tmo=%0d exp 1/1/0", nv, nd, tmo);
    end
    w = (got_q.size() > 0) ? got_q[0] : 140'd0;
    n_checks++;
    if ({w[139:130], w[129:120], w[29:20], w[19:10], w[9:0]} !== {10'h000, 10'h3FF, 10'h3FF, 10'h000, 10'h3FF}) begin
      n_fail++; $display("FAIL const_slices got=%h exp=%h", {w[139:130], w[129:120], w[29:20], w[19:10], w[9:0]},
                         {10'h000, 10'h3FF, 10'h3FF, 10'h000, 10'h3FF});
    end
    e = word_errs();
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL const_words bad=%0d first k=%0d s=%0d", e, bad_k, bad_s); end
  endtask

  task automatic test_ramp();
    bit ack, tmo;
    int nv, nd, e;
    m_mode = 1; m_la = 4090; m_step = 1; m_burst = 2; m_clk = 2;
    load_cfg(ack);
    do_run(10, nv, nd, tmo);
    n_checks++;
    if (nv != 2 || nd != 1 || tmo) begin
      n_fail++; $display("FAIL ramp_burst valid=%0d done=%0d tmo=%0d exp 2/1/0", nv, nd, tmo);
    end
    n_checks++;
    if (got_q.size() != 2 || unpk(got_q[0], 5) != 4095 || unpk(got_q[0], 6) != 0 || unpk(got_q[1], 9) != 13) begin
      n_fail++; $display("FAIL ramp_wrap words=%0d exp 2 with w0s5=4095 w0s6=0 w1s9=13", got_q.size());
    end
    e = word_errs();
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL ramp_words bad=%0d first k=%0d s=%0d", e, bad_k, bad_s); end
    n_checks++;
    if (bus.word_count !== 16'd2) begin n_fail++; $display("FAIL ramp_word_count got=%0d exp=2", bus.word_count); end
  endtask

  task automatic test_pulse();
    bit ack, tmo;
    int nv, nd, e, hi;
    m_mode = 2; m_la = 'hF9C; m_lb = 100; m_period = 8; m_width = 2; m_burst = 16; m_clk = 3;
    load_cfg(ack);
    do_run(30, nv, nd, tmo);
    n_checks++;
    if (nv != 16 || nd != 1 || tmo || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL pulse_burst valid=%0d done=%0d tmo=%0d busy=%b exp 16/1/0/0", nv, nd, tmo, bus.busy);
    end
    hi = 0;
    foreach (got_q[k]) if (unpk(got_q[k], 0) == 100) hi++;
    n_checks++;
    if (hi != 4) begin n_fail++; $display("FAIL pulse_high_words got=%0d exp=4", hi); end
    e = word_errs();
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL pulse_words bad=%0d first k=%0d s=%0d", e, bad_k, bad_s); end
  endtask

  task automatic test_stop();
    bit ack;
    int nv, e;
    m_mode = 1; m_la = int'($urandom_range(0, 4095)); m_step = int'($urandom_range(0, 4095));
    m_burst = 0; m_clk = 1;
    load_cfg(ack);
    got_q.delete();
    nv = 0;
    bus.start = 1'b1;
    @(negedge clklvds);
    bus.start = 1'b0;
    repeat (5) begin
      @(negedge clklvds);
      if (bus.pat_valid) begin nv++; got_q.push_back(bus.pat_bits); end
    end
    bus.stop = 1'b1;
    @(negedge clklvds);
    bus.stop = 1'b0;
    n_checks++;
    if ({bus.pat_valid, bus.busy, bus.done} !== 3'b000 || bus.word_count !== 16'd5) begin
      n_fail++; $display("FAIL stop_abort valid/busy/done=%b count=%0d exp 000 and 5",
                         {bus.pat_valid, bus.busy, bus.done}, bus.word_count);
    end
    @(negedge clklvds);
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL stop_no_done got=%b exp=0", bus.done); end
    e = word_errs();
    n_checks++;
    if (nv != 5 || e != 0) begin n_fail++; $display("FAIL stop_words valid=%0d bad=%0d exp 5/0", nv, e); end
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clklvds);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    @(negedge clklvds);
    n_checks++;
    if ({bus.busy, bus.pat_valid} !== 2'b00) begin
      n_fail++; $display("FAIL stop_over_start busy/valid=%b exp=00", {bus.busy, bus.pat_valid});
    end
  endtask

  task automatic test_cfg_in_run();
    bit ack, tmo;
    int nv, nd, e;
    m_mode = 0; m_la = 'h123; m_burst = 0; m_clk = 2;
    load_cfg(ack);
    bus.start = 1'b1;
    @(negedge clklvds);
    bus.start = 1'b0;
    repeat (3) @(negedge clklvds);
    bus.cfg_level_a = 12'h456;
    bus.cfg_load = 1'b1;
    @(negedge clklvds);
    bus.cfg_load = 1'b0;
    n_checks++;
    if (bus.cfg_ack !== 1'b0) begin n_fail++; $display("FAIL run_load_ack got=%b exp=0", bus.cfg_ack); end
    @(negedge clklvds);
    n_checks++;
    if (bus.cfg_ack !== 1'b0 || bus.pat_valid !== 1'b1 || unpk(bus.pat_bits, 0) != 'h123) begin
      n_fail++; $display("FAIL run_load_ignored ack=%b valid=%b level=%h exp 0/1/123",
                         bus.cfg_ack, bus.pat_valid, unpk(bus.pat_bits, 0));
    end
    bus.stop = 1'b1;
    @(negedge clklvds);
    bus.stop = 1'b0;
    m_la = 'h456; m_burst = 2;
    load_cfg(ack);
    n_checks++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL idle_load_ack got=%b exp=1", ack); end
    @(negedge clklvds);
    n_checks++;
    if (bus.cfg_ack !== 1'b0) begin n_fail++; $display("FAIL idle_ack_width got=%b exp=0", bus.cfg_ack); end
    do_run(10, nv, nd, tmo);
    e = word_errs();
    n_checks++;
    if (nv != 2 || e != 0) begin n_fail++; $display("FAIL reload_run valid=%0d bad=%0d exp 2/0", nv, e); end
  endtask

  task automatic test_load_with_start();
    int nv, e, cyc;
    m_mode = 1; m_la = int'($urandom_range(0, 4095)); m_step = int'($urandom_range(1, 4095));
    m_burst = 4; m_clk = 0;
    drive_cfg();
    got_q.delete();
    bus.cfg_load = 1'b1;
    bus.start    = 1'b1;
    @(negedge clklvds);
    bus.cfg_load = 1'b0;
    bus.start    = 1'b0;
    n_checks++;
    if ({bus.cfg_ack, bus.busy} !== 2'b11) begin
      n_fail++; $display("FAIL load_start ack/busy=%b exp=11", {bus.cfg_ack, bus.busy});
    end
    nv = 0; cyc = 0;
    while (bus.busy && cyc < 20) begin
      @(negedge clklvds);
      cyc++;
      if (bus.pat_valid) begin nv++; got_q.push_back(bus.pat_bits); end
    end
    e = word_errs();
    n_checks++;
    if (nv != 4 || e != 0 || bus.busy) begin
      n_fail++; $display("FAIL load_start_words valid=%0d bad=%0d busy=%b exp 4/0/0", nv, e, bus.busy);
    end
  endtask

  task automatic test_random();
    bit ack, tmo;
    int nv, nd, e;
    for (int it = 0; it < 25; it++) begin
      m_mode   = int'($urandom_range(0, 3));
      m_la     = int'($urandom_range(0, 4095));
      m_lb     = int'($urandom_range(0, 4095));
      m_step   = int'($urandom_range(0, 4095));
      m_period = int'($urandom_range(0, 6));
      m_width  = int'($urandom_range(0, 7));
      m_burst  = int'($urandom_range(1, 12));
      m_clk    = int'($urandom_range(0, 3));
      load_cfg(ack);
      do_run(m_burst + 5, nv, nd, tmo);
      e = word_errs();
      n_checks++;
      if (!ack || nv != m_burst || nd != 1 || tmo) begin
        n_fail++; $display("FAIL rand_run it=%0d ack=%b valid=%0d done=%0d tmo=%0d exp 1/%0d/1/0",
                           it, ack, nv, nd, tmo, m_burst);
      end
      n_checks++;
      if (e != 0 || bus.word_count != 16'(m_burst)) begin
        n_fail++; $display("FAIL rand_words it=%0d mode=%0d bad=%0d k=%0d s=%0d count=%0d exp 0 and %0d",
                           it, m_mode, e, bad_k, bad_s, bus.word_count, m_burst);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ack, tmo;
    int nv, nd;
    m_mode = 0; m_la = int'($urandom_range(1, 4095)); m_burst = 20; m_clk = 3;
    load_cfg(ack);
    bus.start = 1'b1;
    @(negedge clklvds);
    bus.start = 1'b0;
    repeat (3) @(negedge clklvds);
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({bus.pat_valid, bus.busy, bus.done} !== 3'b000 || bus.pat_bits !== 140'd0 || bus.word_count !== 16'd0) begin
      n_fail++; $display("FAIL async_clear valid/busy/done=%b count=%0d exp 000 and 0",
                         {bus.pat_valid, bus.busy, bus.done}, bus.word_count);
    end
    @(negedge clklvds);
    rstn = 1'b1;
    @(negedge clklvds);
    m_mode = 0; m_la = 0; m_lb = 0; m_step = 0; m_period = 1; m_width = 0; m_burst = 0; m_clk = 0;
    do_run(5, nv, nd, tmo);
    n_checks++;
    if (!tmo) begin
      n_fail++; $display("FAIL default_burst continuous run ended early valid=%0d exp still busy", nv);
    end
    n_checks++;
    if (got_q.size() == 0 || got_q[0] !== 140'd0) begin
      n_fail++; $display("FAIL default_const words=%0d first=%h exp zero word", got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : 140'd0);
    end
    bus.stop = 1'b1;
    @(negedge clklvds);
    bus.stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_mode = '0; bus.cfg_level_a = '0; bus.cfg_level_b = '0; bus.cfg_step = '0;
    bus.cfg_period = '0; bus.cfg_width = '0; bus.cfg_burst = '0; bus.cfg_clkstr = '0;
    bus.cfg_load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    m_mode = 0; m_la = 0; m_lb = 0; m_step = 0; m_period = 1; m_width = 0; m_burst = 0; m_clk = 0;
    repeat (2) @(negedge clklvds);
    test_reset();
    rstn = 1'b1;
    @(negedge clklvds);
    test_const();
    test_ramp();
    test_pulse();
    test_stop();
    test_cfg_in_run();
    test_load_with_start();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_pattern_gen.md
Name: adc_pattern_gen

Overview:
- Synthetic ADC source in the clklvds domain.
- Drives 140-bit words in the deserializer's bit-interleaved format, so it can stand in for lvds1bits..lvds4bits during self-test and bench runs of the acquisition/trigger path.
- Produces constant, ramp and pulse patterns, in finite bursts or continuously, under a load/start/stop handshake.

Parameters:
NSAMP, 10, samples per word
SWIDTH, 12, sample width, two's complement
CSWIDTH, 2, clock-strobe bits per sample
CNTW, 16, width of period/width/burst/word counters

Ports:
clklvds  in  1  clock
rstn  in  1  async active-low reset
cfg_mode  in  2  0=CONST 1=RAMP 2=PULSE 3=reserved (behaves as CONST)
cfg_level_a  in  SWIDTH  CONST level; RAMP start; PULSE baseline
cfg_level_b  in  SWIDTH  PULSE high level
cfg_step  in  SWIDTH  RAMP increment per sample
cfg_period  in  CNTW  PULSE period in words
cfg_width  in  CNTW  PULSE high width in words
cfg_burst  in  CNTW  words per run; 0=continuous
cfg_clkstr  in  CSWIDTH  strobe bits stamped on every sample
cfg_load  in  1  latch cfg_* (IDLE only)
cfg_ack  out  1  one-cycle pulse: load accepted
start  in  1  begin run
stop  in  1  abort run
busy  out  1  high in RUN
pat_bits  out  NSAMP*(SWIDTH+CSWIDTH)  packed word
pat_valid  out  1  pat_bits holds a generated word
done  out  1  one-cycle pulse at burst end
word_count  out  CNTW  words emitted this run, saturating

Behaviour:
- Reset (async, rstn low): all outputs 0; shadow config = mode 0, levels 0, step 0, period 1, width 0, burst 0, clkstr 0; state IDLE.
- Packing: sample s (0 = earliest), bit b (0..13) -> pat_bits[NSAMP*b + s].
  - Bits 0..11 carry the sample value; bit 12 = clkstr[0]; bit 13 = clkstr[1].
- States:
  - IDLE -> RUN on start.
  - RUN -> IDLE on stop, or after cfg_burst words when cfg_burst != 0.
- cfg_load in IDLE:
  - Shadow registers update at that edge; cfg_ack = 1 the next cycle.
  - If cfg_load and start are high together, the new config applies to the run.
- cfg_load in RUN: ignored, no cfg_ack.
- Start timing: start sampled at edge N:
  - N: busy = 1, word_count = 0, pattern state initialised.
  - N+1: first word registered, pat_valid = 1.
  - Then one word per cycle; there is no back-pressure.
- Burst B > 0:
  - Exactly B cycles with pat_valid = 1.
  - On the edge after the last word: pat_valid = 0, busy = 0, done = 1 for one cycle.
- Stop:
  - stop sampled high in RUN: pat_valid = 0 and busy = 0 at the next edge; no done pulse.
  - stop has priority over start when both are high.
  - stop in IDLE: no effect.
- start while in RUN: ignored.
- word_count: increments with each valid word; saturates at 2^CNTW-1; holds its value in IDLE until the next start.
- CONST: every sample = level_a.
- RAMP:
  - Word k, sample s = level_a + (NSAMP*k + s)*step, modulo 2^SWIDTH.
  - Implementation: a base register advances by NSAMP*step per word, all arithmetic truncated to SWIDTH.
- PULSE:
  - Phase counter runs 0..period-1 per word, wrapping; it starts at 0 on each run.
  - phase < width -> all samples = level_b; otherwise level_a.
  - period 0 is treated as 1.
  - width >= period -> all words level_b; width 0 -> all words level_a.
- Async reset mid-run: outputs clear immediately, no done pulse, config returns to defaults.

Decomposition:
- Package adc_pattern_pkg holds:
  - mode constants MODE_CONST/RAMP/PULSE;
  - NSAMP, SWIDTH, CSWIDTH and derived word width;
  - state enum IDLE/RUN.
- Sub-module lvds_word_pack: combinational interleaver, NSAMP samples + clkstr -> word, per the packing rule above.
  - Reusable by benches as the golden packer; an inverse unpack function also lives in the package.

Test Plan:
- CONST, level_a=12'h5A5, clkstr=2'b01, burst 1 -> expected word:
  - pat_bits[9:0]=10'h3FF, [19:10]=0, [29:20]=10'h3FF, [129:120]=10'h3FF, [139:130]=0;
  - one pat_valid cycle, then done pulse.
- RAMP, level_a=4090, step 1, burst 2:
  - Word0 samples = 4090..4095, 0..3.
  - Word1 samples = 4..13.
  - word_count ends at 2.
- PULSE, level_a=12'hF9C (-100), level_b=100, period 8, width 2, burst 16:
  - Words 0, 1, 8, 9 carry 100; all other words carry -100.
  - Exactly 16 valid cycles, one done pulse, busy low afterward.
- Continuous RAMP, stop raised after 5 words:
  - pat_valid low at the next edge, word_count = 5, no done pulse.
  - start with stop high simultaneously -> stays IDLE.
- cfg_load in RUN with a new level -> no cfg_ack, output unchanged; reload in IDLE -> cfg_ack one cycle later, and the next run uses the new level.
- rstn pulsed low mid-burst -> pat_valid/busy/done clear immediately; after release, IDLE with default config (CONST 0).
